// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch PC sequencer.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [1:0] RK_BRANCH = 2'd0;
    localparam logic [1:0] RK_JUMP   = 2'd1;
    localparam logic [1:0] RK_JR     = 2'd2;
    localparam logic [1:0] RK_RSVD   = 2'd3;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational redirect-target calculator for branch, jump and jr.
module next_pc_calc
    import cpu_fetch_pkg::*;
(
    input  logic [1:0]  redirect_kind,
    input  logic [31:0] pc,
    input  logic [15:0] imm16,
    input  logic [25:0] index26,
    input  logic [31:0] jr_reg,
    output logic [31:0] target,
    output logic        misalign
);

    logic [31:0] p4;
    logic [31:0] branch_off;

    assign p4         = pc + 32'd4;
    assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        target   = p4;
        misalign = 1'b0;
        case (redirect_kind)
            RK_BRANCH: target = p4 + branch_off;
            RK_JUMP:   target = {p4[31:28], index26, 2'b00};
            RK_JR: begin
                // Low bits are forced to zero; the fault is only flagged.
                target   = {jr_reg[31:2], 2'b00};
                misalign = (jr_reg[1:0] != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
module fetch_pc_sequencer
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_kind,
    input  logic [31:0] redirect_pc,
    input  logic [15:0] redirect_imm16,
    input  logic [25:0] redirect_index26,
    input  logic [31:0] redirect_reg,
    output logic        misalign_err
);

    fetch_state_e state_reg, state_next;
    logic [31:0]  pc_reg, pc_next;
    logic         discard_reg, discard_next;
    logic         instr_valid_reg, instr_valid_next;
    logic [31:0]  instr_reg, instr_next;
    logic [31:0]  instr_pc_reg, instr_pc_next;
    logic         misalign_reg, misalign_next;

    logic [31:0]  calc_target;
    logic         calc_misalign;
    logic         redirect_take;
    fetch_state_e resume_state;

    next_pc_calc u_next_pc_calc (
        .redirect_kind (redirect_kind),
        .pc            (redirect_pc),
        .imm16         (redirect_imm16),
        .index26       (redirect_index26),
        .jr_reg        (redirect_reg),
        .target        (calc_target),
        .misalign      (calc_misalign)
    );

    assign redirect_take = redirect_valid && (redirect_kind != RK_RSVD);
    assign resume_state  = fetch_en ? REQ : IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            pc_reg          <= RESET_PC;
            discard_reg     <= 1'b0;
            instr_valid_reg <= 1'b0;
            instr_reg       <= 32'd0;
            instr_pc_reg    <= 32'd0;
            misalign_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            discard_reg     <= discard_next;
            instr_valid_reg <= instr_valid_next;
            instr_reg       <= instr_next;
            instr_pc_reg    <= instr_pc_next;
            misalign_reg    <= misalign_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        discard_next     = discard_reg;
        instr_valid_next = instr_valid_reg;
        instr_next       = instr_reg;
        instr_pc_next    = instr_pc_reg;
        misalign_next    = misalign_reg;

        if (redirect_take) begin
            // A redirect overrides every other event this cycle.
            pc_next       = calc_target;
            misalign_next = misalign_reg | calc_misalign;
            case (state_reg)
                IDLE: ;
                REQ: begin
                    if (imem_gnt) begin
                        state_next   = WAIT;
                        discard_next = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        discard_next = 1'b0;
                        state_next   = resume_state;
                    end else begin
                        discard_next = 1'b1;
                    end
                end
                HOLD: begin
                    instr_valid_next = 1'b0;
                    state_next       = resume_state;
                end
                default: ;
            endcase
        end else begin
            case (state_reg)
                IDLE: begin
                    if (fetch_en) state_next = REQ;
                end
                REQ: begin
                    if (imem_gnt) state_next = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (discard_reg) begin
                            discard_next = 1'b0;
                            state_next   = resume_state;
                        end else begin
                            instr_next       = imem_rdata;
                            instr_pc_next    = pc_reg;
                            instr_valid_next = 1'b1;
                            pc_next          = pc_reg + 32'd4;
                            state_next       = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr_valid_next = 1'b0;
                        state_next       = resume_state;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_req     = (state_reg == REQ);
    assign imem_addr    = pc_reg;
    assign instr_valid  = instr_valid_reg;
    assign instr        = instr_reg;
    assign instr_pc     = instr_pc_reg;
    assign misalign_err = misalign_reg;

endmodule
